sfifo_flags: RTL and testbench
==============================

# sfifo_flags

Parametrised single-clock FIFO: the next-generation synchronous buffer for byte and word streams between same-clock producer/consumer blocks. Adds configurable depth/width, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, correct simultaneous read/write accounting, and optional first-word-fall-through output.

## Interface
- WIDTH, 8: data width in bits, ≥1
- DEPTH, 16: entries; power of two, ≥2
- AFULL_TH, 12: almost_full asserts when count ≥ AFULL_TH; 1 ≤ AFULL_TH ≤ DEPTH
- AEMPTY_TH, 2: almost_empty asserts when count ≤ AEMPTY_TH; 0 ≤ AEMPTY_TH < DEPTH
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- din  in  WIDTH  write data
- wr_en  in  1  write request
- rd_en  in  1  read request
- clr_err  in  1  synchronous clear of overflow/underflow
- dout  out  WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_TH
- almost_empty  out  1  count ≤ AEMPTY_TH
- count  out  $clog2(DEPTH)+1  occupancy
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Reset: pointers 0, count 0, dout 0, empty 1, almost_empty 1, full 0, almost_full 0, overflow 0, underflow 0. Memory contents not reset.
- wr_acc = wr_en & !full; rd_acc = rd_en & !empty (flags as registered in the current cycle).
- wr_acc: mem[wr_ptr] ← din, wr_ptr increments, wraps DEPTH-1 → 0 naturally (AW-bit pointer).
- rd_acc: rd_ptr increments with the same wrap.
- count_next = count + wr_acc − rd_acc; both accepted → count unchanged. Never exceeds DEPTH, never below 0.
- Full + wr_en + rd_en: read accepted, write rejected, overflow sets; count → DEPTH-1.
- Empty + wr_en + rd_en: write accepted, read rejected, underflow sets; count → 1.
- All status flags registered, computed from count_next; always consistent with count in the same cycle.
- overflow sets on wr_en & full; underflow sets on rd_en & empty; clr_err clears both; set wins over clear in the same cycle.
- Rejected requests change no pointer, count or memory.
- Registered-output mode (default): on rd_acc, dout ← mem[rd_ptr]; otherwise dout holds.

## Timing
- Write at edge N: empty deasserts, count increments after edge N.
- Default mode: rd_en in cycle N+1 → dout valid after edge N+1; minimum write-to-data latency 2 edges.
- Flags/count: one edge after the accepting edge; no combinational path from wr_en/rd_en to any output in default mode.
- Full throughput: one write and one read per cycle sustained.
- rst mid-operation: all state returns to reset values immediately; stored data is lost.

## Configuration
- FIFO_FWFT_EN defined: first-word-fall-through. dout = mem[rd_ptr] combinationally whenever !empty; head word visible one edge after the write that made the FIFO non-empty; rd_en pops (acknowledges) the displayed word. dout is don't-care while empty. Flags, count and error behaviour unchanged.
- Undefined: registered-output mode per Operation.

## Structure
- Package sfifo_pkg: default WIDTH/DEPTH/threshold constants, address-width helper function (clog2), parameter-legality checks used by elaboration assertions.
- Sub-module sfifo_ram: DEPTH×WIDTH storage, one synchronous write port, one asynchronous read port; sfifo_flags owns pointers, count, flags, dout register.
- Elaboration-time error on non-power-of-two DEPTH or out-of-range thresholds.

## Test plan
- Reset then 16 writes 0x00..0x0F (WIDTH=8, DEPTH=16) → count 16, full 1, almost_full 1 from 12th write; 16 reads return 0x00..0x0F in order, empty 1 after last.
- Full FIFO, wr_en=1 with din=0xAA, no read → count stays 16, overflow 1, 0xAA never read; clr_err → overflow 0.
- Empty FIFO, rd_en=1 → underflow 1, dout holds 0, count 0; same-cycle rd_en+clr_err → underflow remains 1.
- Count 8, wr_en+rd_en for 40 cycles with incrementing data → count constant 8, pointers wrap, data order preserved.
- Full + simultaneous wr_en/rd_en → count 15, overflow 1, head word read out; empty + both → count 1, underflow 1.
- With FIFO_FWFT_EN: single write 0x5C → dout 0x5C visible one edge later with rd_en=0; rd_en pops, empty 1; rst asserted with count 5 → count 0, empty 1 immediately.

Source files
------------

// File: rtl/sfifo_pkg.sv
// Shared constants and elaboration-time helpers for the sfifo_flags FIFO.
// The optional FIFO_FWFT_EN build macro is consumed by sfifo_flags.sv.
package sfifo_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_AFULL_TH  = 12;
    localparam int DEF_AEMPTY_TH = 2;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit thresholds_ok(input int depth, input int afull_th,
                                         input int aempty_th);
        return (afull_th >= 1) && (afull_th <= depth) &&
               (aempty_th >= 0) && (aempty_th < depth);
    endfunction

    function automatic bit width_ok(input int width);
        return width >= 1;
    endfunction

endpackage

// File: rtl/sfifo_if.sv
// Producer/consumer-facing bundle of the FIFO. The FIFO uses the slave modport;
// the block driving writes/reads and observing status uses master.
interface sfifo_if import sfifo_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int CW = clog2(DEPTH) + 1;

    logic [WIDTH-1:0] din;
    logic             wr_en;
    logic             rd_en;
    logic             clr_err;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output din, wr_en, rd_en, clr_err,
        input  dout, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

    modport slave (
        input  din, wr_en, rd_en, clr_err,
        output dout, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

endinterface

// File: rtl/sfifo_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module sfifo_ram import sfifo_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sfifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and
// sticky error flags. Define FIFO_FWFT_EN for first-word-fall-through output.
module sfifo_flags import sfifo_pkg::*; #(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AFULL_TH  = DEF_AFULL_TH,
    parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
    input  logic  clk,
    input  logic  rst,
    sfifo_if.slave bus
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("sfifo_flags: WIDTH must be >= 1");
    end
    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("sfifo_flags: DEPTH must be a power of two >= 2");
    end
    if (!thresholds_ok(DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_bad_th
        $error("sfifo_flags: AFULL_TH/AEMPTY_TH out of range");
    end

    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full, r_empty, r_afull, r_aempty;
    logic             r_ovf, r_udf;

    logic             w_wr_acc, w_rd_acc;
    logic [CW-1:0]    w_count_next;
    logic [WIDTH-1:0] w_rd_data;

    // Acceptance uses the registered flags only, so no request input reaches
    // an output combinationally.
    assign w_wr_acc = bus.wr_en & ~r_full;
    assign w_rd_acc = bus.rd_en & ~r_empty;

    assign w_count_next = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);

    sfifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.din),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count  <= w_count_next;
            r_full   <= (w_count_next == CW'(DEPTH));
            r_empty  <= (w_count_next == '0);
            r_afull  <= (w_count_next >= CW'(AFULL_TH));
            r_aempty <= (w_count_next <= CW'(AEMPTY_TH));
            // Set has priority over clear.
            r_ovf    <= (bus.wr_en & r_full)  | (r_ovf & ~bus.clr_err);
            r_udf    <= (bus.rd_en & r_empty) | (r_udf & ~bus.clr_err);
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word shown directly from storage; rd_en acknowledges it.
    assign bus.dout = w_rd_data;
`else
    logic [WIDTH-1:0] r_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_dout <= '0;
        else if (w_rd_acc) r_dout <= w_rd_data;
    end

    assign bus.dout = r_dout;
`endif

    assign bus.count        = r_count;
    assign bus.full         = r_full;
    assign bus.empty        = r_empty;
    assign bus.almost_full  = r_afull;
    assign bus.almost_empty = r_aempty;
    assign bus.overflow     = r_ovf;
    assign bus.underflow    = r_udf;

endmodule

// File: tb/tb_sfifo_flags.sv
// Directed self-checking bench for sfifo_flags (WIDTH=8, DEPTH=16, AF=12, AE=2);
// read-data expectations adapt to FIFO_FWFT_EN when that macro is defined.
module tb_sfifo_flags;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    sfifo_if #(.WIDTH(8), .DEPTH(16)) bus ();

    sfifo_flags #(
        .WIDTH     (8),
        .DEPTH     (16),
        .AFULL_TH  (12),
        .AEMPTY_TH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pop one word and check it; caller owns wr_en/din and deasserts rd_en.
    task automatic pop_chk(input logic [7:0] exp, input string tag);
`ifdef FIFO_FWFT_EN
        chk(tag, {24'd0, bus.dout}, {24'd0, exp});
        bus.rd_en = 1'b1;
        tick();
`else
        bus.rd_en = 1'b1;
        tick();
        chk(tag, {24'd0, bus.dout}, {24'd0, exp});
`endif
    endtask

    task automatic fill(input logic [7:0] base, input int n);
        bus.wr_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.din = base + 8'(i);
            tick();
        end
        bus.wr_en = 1'b0;
    endtask

    initial begin
        bus.din = '0; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.clr_err = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_aempty", 32'(bus.almost_empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_afull", 32'(bus.almost_full), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);
        chk("rst_udf", 32'(bus.underflow), 0);
`ifndef FIFO_FWFT_EN
        chk("rst_dout", 32'(bus.dout), 0);
`endif
        rst = 1'b0;
        tick();

        // Underflow on empty read; set beats clear; clear alone works
        bus.rd_en = 1'b1; tick();
        chk("udf_set", 32'(bus.underflow), 1);
        chk("udf_count", 32'(bus.count), 0);
        chk("udf_empty", 32'(bus.empty), 1);
`ifndef FIFO_FWFT_EN
        chk("udf_dout", 32'(bus.dout), 0);
`endif
        bus.clr_err = 1'b1; tick();
        chk("udf_set_wins", 32'(bus.underflow), 1);
        bus.rd_en = 1'b0; tick();
        chk("udf_clr", 32'(bus.underflow), 0);
        bus.clr_err = 1'b0;

        // Fill 0x00..0x0F with flag tracking
        bus.wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.din = 8'(i);
            tick();
            chk("fill_count", 32'(bus.count), 32'(i + 1));
            chk("fill_afull", 32'(bus.almost_full), 32'((i + 1) >= 12));
            chk("fill_aempty", 32'(bus.almost_empty), 32'((i + 1) <= 2));
            chk("fill_empty", 32'(bus.empty), 0);
        end
        chk("fill_full", 32'(bus.full), 1);

        // Overflow: write 0xAA while full
        bus.din = 8'hAA; tick();
        bus.wr_en = 1'b0;
        chk("ovf_set", 32'(bus.overflow), 1);
        chk("ovf_count", 32'(bus.count), 16);
        chk("ovf_full", 32'(bus.full), 1);
        bus.clr_err = 1'b1; tick(); bus.clr_err = 1'b0;
        chk("ovf_clr", 32'(bus.overflow), 0);

        // Drain in order; 0xAA must never appear
        for (int i = 0; i < 16; i++) pop_chk(8'(i), "drain_data");
        bus.rd_en = 1'b0;
        chk("drain_empty", 32'(bus.empty), 1);
        chk("drain_count", 32'(bus.count), 0);
        chk("drain_aempty", 32'(bus.almost_empty), 1);
        chk("drain_full", 32'(bus.full), 0);

        // Steady state: count 8, 40 cycles of simultaneous write/read
        fill(8'h10, 8);
        chk("ss_count0", 32'(bus.count), 8);
        bus.wr_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            bus.din = 8'h18 + 8'(k);
            pop_chk(8'h10 + 8'(k), "ss_data");
            chk("ss_count", 32'(bus.count), 8);
        end
        bus.wr_en = 1'b0;
        for (int k = 0; k < 8; k++) pop_chk(8'h38 + 8'(k), "ss_tail");
        bus.rd_en = 1'b0;
        chk("ss_empty", 32'(bus.empty), 1);

        // Full + simultaneous write/read: read wins, write rejected
        fill(8'h40, 16);
        chk("fb_full0", 32'(bus.full), 1);
        bus.wr_en = 1'b1; bus.din = 8'hBB;
        pop_chk(8'h40, "fb_head");
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        chk("fb_count", 32'(bus.count), 15);
        chk("fb_ovf", 32'(bus.overflow), 1);
        chk("fb_full", 32'(bus.full), 0);
        chk("fb_afull", 32'(bus.almost_full), 1);
        bus.clr_err = 1'b1; tick(); bus.clr_err = 1'b0;
        for (int i = 1; i < 16; i++) pop_chk(8'h40 + 8'(i), "fb_drain");
        bus.rd_en = 1'b0;
        chk("fb_empty", 32'(bus.empty), 1);

        // Empty + simultaneous write/read: write wins, read rejected
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.din = 8'hCC;
        tick();
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        chk("eb_count", 32'(bus.count), 1);
        chk("eb_udf", 32'(bus.underflow), 1);
        chk("eb_empty", 32'(bus.empty), 0);
        pop_chk(8'hCC, "eb_data");
        bus.rd_en = 1'b0;
        chk("eb_empty2", 32'(bus.empty), 1);
        bus.clr_err = 1'b1; tick(); bus.clr_err = 1'b0;

        // Asynchronous reset mid-operation
        fill(8'h70, 5);
        chk("ar_count0", 32'(bus.count), 5);
        #2 rst = 1'b1;
        #1;
        chk("ar_count", 32'(bus.count), 0);
        chk("ar_empty", 32'(bus.empty), 1);
        chk("ar_aempty", 32'(bus.almost_empty), 1);
        tick();
        rst = 1'b0;
        tick();
        fill(8'h5C, 1);
        pop_chk(8'h5C, "ar_after");
        bus.rd_en = 1'b0;
        chk("ar_after_empty", 32'(bus.empty), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
